// File: rtl/sum_display_if.sv
//------------------------------------------------------------------------------
// Module   : sum_display_if
// Purpose  : Bundles the adder-sum input and the 7-segment display pins of
//            sum_display into one interface.
// Signals  : sum  [4:0]  unsigned adder sum (0..31)
//            seg  [6:0]  segments {g,f,e,d,c,b,a}
//            dp          decimal point (always inactive)
//            an   [1:0]  digit enables, an[0] = units, an[1] = tens
//            busy        conversion in progress
// Modports : master - drives sum, observes the display pins
//            slave  - the display block (sum_display)
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

interface sum_display_if;
  logic [4:0] sum;
  logic [6:0] seg;
  logic       dp;
  logic [1:0] an;
  logic       busy;

  modport master (
    output sum,
    input  seg,
    input  dp,
    input  an,
    input  busy
  );

  modport slave (
    input  sum,
    output seg,
    output dp,
    output an,
    output busy
  );
endinterface

`default_nettype wire

// File: rtl/sum_display.sv
//------------------------------------------------------------------------------
// Module   : sum_display
// Purpose  : Converts the 5-bit adder sum into two decimal digits with a
//            sequential subtract-by-ten machine and scans them onto a
//            two-digit multiplexed 7-segment display. Tens digit is blanked
//            when zero.
// Ports    : clk          system clock, rising edge
//            rst          asynchronous active-high reset
//            bus (slave)  sum in; seg/dp/an/busy out (see sum_display_if)
// Params   : REFRESH_DIV  cycles per digit before the scan advances (>= 2)
//            SEG_ACT_LOW  1 = active-low segments/anodes, 0 = active-high
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module sum_display #(
  parameter int REFRESH_DIV = 50000,
  parameter bit SEG_ACT_LOW = 1'b1
) (
  input  logic         clk,
  input  logic         rst,
  sum_display_if.slave bus
);

  localparam int               c_cnt_w   = $clog2(REFRESH_DIV);
  localparam logic [c_cnt_w-1:0] c_cnt_max = c_cnt_w'(REFRESH_DIV - 1);
  // XOR masks that turn the internal active-low encoding into pin polarity
  localparam logic [6:0]       c_seg_pol = SEG_ACT_LOW ? 7'b0000000 : 7'b1111111;
  localparam logic [1:0]       c_an_pol  = SEG_ACT_LOW ? 2'b00 : 2'b11;
  localparam logic [6:0]       c_seg_off = 7'b1111111;
  localparam logic [6:0]       c_seg_0   = 7'b1000000;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CONV = 2'd1,
    S_LOAD = 2'd2
  } state_t;

  state_t       r_state;
  state_t       w_state_nxt;

  logic [4:0]   r_rem;
  logic [1:0]   r_tens_acc;
  logic [4:0]   r_last_sum;
  logic         r_stale;
  logic [1:0]   r_tens_disp;
  logic [3:0]   r_units_disp;

  logic [c_cnt_w-1:0] r_refresh_cnt;
  logic         r_digit_sel;   // 0 = units, 1 = tens
  logic [6:0]   r_seg;
  logic [1:0]   r_an;

  logic         w_need_conv;
  logic         w_rem_ge10;
  logic [3:0]   w_digit;
  logic         w_blank;
  logic [6:0]   w_seg_al;
  logic [1:0]   w_an_al;

  // Active-low 7-segment pattern {g,f,e,d,c,b,a}; codes above 9 are blank
  function automatic logic [6:0] f_dec7(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'b1000000;
      4'd1:    s = 7'b1111001;
      4'd2:    s = 7'b0100100;
      4'd3:    s = 7'b0110000;
      4'd4:    s = 7'b0011001;
      4'd5:    s = 7'b0010010;
      4'd6:    s = 7'b0000010;
      4'd7:    s = 7'b1111000;
      4'd8:    s = 7'b0000000;
      4'd9:    s = 7'b0010000;
      default: s = 7'b1111111;
    endcase
    return s;
  endfunction

  // A conversion is needed after reset (stale) or whenever the sum differs
  // from the last captured value; changes seen while busy are picked up here.
  assign w_need_conv = r_stale || (bus.sum != r_last_sum);
  assign w_rem_ge10  = (r_rem >= 5'd10);

  //--------------------------------------------------------------------------
  // Conversion state machine
  //--------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_need_conv) w_state_nxt = S_CONV;
      S_CONV:  if (!w_rem_ge10) w_state_nxt = S_LOAD;
      S_LOAD:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rem        <= 5'd0;
      r_tens_acc   <= 2'd0;
      r_last_sum   <= 5'd0;
      r_stale      <= 1'b1;
      r_tens_disp  <= 2'd0;
      r_units_disp <= 4'd0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_need_conv) begin
            r_rem      <= bus.sum;
            r_tens_acc <= 2'd0;
            r_last_sum <= bus.sum;
            r_stale    <= 1'b0;
          end
        end
        S_CONV: begin
          if (w_rem_ge10) begin
            r_rem      <= r_rem - 5'd10;
            r_tens_acc <= r_tens_acc + 2'd1;
          end
        end
        S_LOAD: begin
          // rem < 10 here, so its upper bit is always zero
          r_tens_disp  <= r_tens_acc;
          r_units_disp <= r_rem[3:0];
        end
        default: ;
      endcase
    end
  end

  assign bus.busy = (r_state != S_IDLE);

  //--------------------------------------------------------------------------
  // Display scan
  //--------------------------------------------------------------------------
  assign w_digit  = r_digit_sel ? {2'b00, r_tens_disp} : r_units_disp;
  assign w_blank  = r_digit_sel && (r_tens_disp == 2'd0);
  assign w_seg_al = w_blank ? c_seg_off : f_dec7(w_digit);
  // Exactly one anode is selected, derived from a single select bit
  assign w_an_al  = r_digit_sel ? 2'b01 : 2'b10;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_refresh_cnt <= '0;
      r_digit_sel   <= 1'b0;
      r_seg         <= c_seg_0 ^ c_seg_pol;
      r_an          <= 2'b10 ^ c_an_pol;
    end else begin
      if (r_refresh_cnt == c_cnt_max) begin
        r_refresh_cnt <= '0;
        r_digit_sel   <= ~r_digit_sel;
      end else begin
        r_refresh_cnt <= r_refresh_cnt + 1'b1;
      end
      r_seg <= w_seg_al ^ c_seg_pol;
      r_an  <= w_an_al ^ c_an_pol;
    end
  end

  assign bus.seg = r_seg;
  assign bus.an  = r_an;
  assign bus.dp  = SEG_ACT_LOW;

endmodule

`default_nettype wire

// File: doc/sum_display.md
Name: sum_display

Overview:
- Downstream consumer of the 4-bit operand adder's 5-bit sum (0..31).
- Converts the sum to two decimal digits with a sequential subtract-by-ten state machine.
- Drives a time-multiplexed two-digit 7-segment display with registered outputs.
- Sits between the adder output and the board's segment/anode pins, replacing the raw-LED view of the sum.

Parameters:
- REFRESH_DIV, 50000: clock cycles each digit stays enabled before the scan advances (minimum 2).
- SEG_ACT_LOW, 1: 1 = segment and anode outputs active-low (common anode); 0 = active-high.

Ports:
- clk  input  1  system clock; all state on rising edge.
- rst  input  1  asynchronous, active-high reset.
- sum  input  5  unsigned sum from the adder; may change on any cycle.
- seg  output 7  segments {g,f,e,d,c,b,a}.
- dp  output 1  decimal point; always driven inactive.
- an  output 2  digit enables; an[0] = units, an[1] = tens.
- busy  output 1  high while a conversion is in progress.

Behaviour:
- Clock and reset: one clock `clk`; reset `rst` is asynchronous and active-high.
- Reset values (immediate, no clock needed):
  - state=IDLE, busy=0, refresh counter=0, digit select=units.
  - Displayed tens=0, units=0, stale flag=1.
  - an selects units (2'b10 when active-low).
  - seg shows "0" (7'b1000000 when active-low); dp inactive.
- State machine, busy = (state != IDLE):
  - IDLE: if stale=1 or sum != last_sum → capture rem=sum, tens_acc=0, last_sum=sum, stale=0; go to CONV.
  - CONV: if rem >= 10 → rem -= 10, tens_acc += 1, stay. Else go to LOAD.
  - LOAD: displayed tens=tens_acc, units=rem[3:0]; go to IDLE.
- Latency:
  - Capture at edge k; busy is high for cycles k+1 .. k+tens+2; new digits are visible from the edge ending LOAD.
  - Worst case is sum=31: busy high 5 cycles.
- Sum changes during CONV or LOAD are ignored. The change is re-detected in IDLE (sum != last_sum) and triggers a fresh conversion. No value is lost as long as sum is stable for one IDLE cycle.
- Widths: rem 5 bits, tens_acc 2 bits (maximum 3). No overflow is possible for 5-bit inputs.
- Scan:
  - Refresh counter counts 0..REFRESH_DIV-1 and wraps to 0.
  - On the wrap edge the digit select toggles.
  - an and seg are registered: they update on the edge after the select or digit change. Both anodes are never active in the same cycle.
- Decode (active-low form; invert all bits when SEG_ACT_LOW=0):
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001
  - 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000
- Leading-zero blanking: when displayed tens=0, the tens slot drives seg blank (all segments off). Its anode still cycles normally.
- Reset asserted mid-conversion aborts immediately to the reset values. After release, stale=1 forces conversion of the current sum on the first edge.

Test Plan:
- Reset: assert rst with no clock edges.
  - → an=2'b10, seg=1000000, dp=1, busy=0 immediately.
  - Release with sum=0 → one conversion (busy 2 cycles), display remains "0" with tens blank.
- Conversion: REFRESH_DIV=4, sum=23 held.
  - → busy high exactly 4 cycles.
  - Then the units slot shows seg=0110000 and the tens slot shows seg=0100100.
- Worst case: sum=31.
  - → busy high 5 cycles.
  - Units seg=1111001 ("1"), tens seg=0110000 ("3").
- Blanking and scan: REFRESH_DIV=4, sum=7.
  - → an sequence 10,10,10,10,01,01,01,01,10…
  - seg=1111000 while an=10, seg=1111111 while an=01.
  - an is never 00.
- Mid-conversion change: sum=23, then sum=9 one cycle after capture.
  - → display first loads 23.
  - Then one IDLE cycle, busy reasserts for 2 cycles, display loads 9 with tens blank.
- Async reset mid-CONV: assert rst between clock edges while busy=1.
  - → busy=0, an=10, seg=1000000 in the same timestep.
  - After release, the current sum is converted and displayed correctly.
